// File: rtl/ntsc_sync_detect.sv
// ntsc_sync_detect: composite-video sync separator.
// Samples a 4-bit video ADC, glitch-filters the sync-tip level, classifies
// pulse widths as horizontal / equalizing / broad, and derives line count,
// vertical sync, field parity and a horizontal lock indication.
// Build option: define NTSC_SYNC_FIELD_EN to include the EQ-interval field
// measurement; otherwise `field` is tied to 0.
module ntsc_sync_detect #(
    parameter int                DATA_W      = 4,
    parameter logic [DATA_W-1:0] SYNC_THRESH = 4'd2,
    parameter int                GLITCH      = 8,
    parameter int                HSYNC_MIN   = 48,
    parameter int                HSYNC_MAX   = 120,
    parameter int                BROAD_MIN   = 300,
    parameter int                LINE_NOM    = 1016,
    parameter int                LINE_TOL    = 16,
    parameter int                LOCK_LINES  = 8
) (
    input  logic              clk,
    input  logic              NRST,
    input  logic [DATA_W-1:0] vadc,
    output logic              sync_level,
    output logic              hsync_pulse,
    output logic              vsync_pulse,
    output logic              field,
    output logic              locked,
    output logic [9:0]        line_count
);

    localparam int FLT_W  = $clog2(GLITCH);
    localparam int LCNT_W = $clog2(LOCK_LINES + 1);

    typedef enum logic [0:0] {SEARCH, LOCKED} lock_state_t;

    function automatic logic [9:0] sat_inc10(input logic [9:0] v);
        return (v == 10'h3FF) ? v : v + 10'd1;
    endfunction

    function automatic logic [11:0] sat_inc12(input logic [11:0] v);
        return (v == 12'hFFF) ? v : v + 12'd1;
    endfunction

    // Signed distance check of a measured interval against a nominal value.
    function automatic logic within_tol(input logic [11:0] v, input int nom);
        int signed d;
        d = int'(v) - nom;
        return (d <= LINE_TOL) && (d >= -LINE_TOL);
    endfunction

    logic [DATA_W-1:0] vadc_p0;
    logic [DATA_W-1:0] vadc_p1;
    logic              raw;
    logic [FLT_W-1:0]  flt_cnt;
    logic              sync_d;
    logic              rise;
    logic              fall;
    logic              idle_seen;
    logic              armed;
    logic [9:0]        width;
    logic [11:0]       interval;
    logic [11:0]       rise_interval;
    logic [1:0]        broad_run;
    logic              cls_en;
    logic              is_h;
    logic              is_eq;
    logic              is_broad;
    logic              cls_any;
    lock_state_t       state;
    logic [LCNT_W-1:0] lock_cnt;
    logic [11:0]       tmo;

    // Stage p0/p1: double-register the ADC sample (data path, no reset)
    always_ff @(posedge clk) begin
        vadc_p0 <= vadc;
        vadc_p1 <= vadc_p0;
    end

    assign raw = (vadc_p1 <= SYNC_THRESH);

    // Glitch filter: flip the level only after GLITCH consecutive disagreeing samples
    always_ff @(posedge clk) begin
        if (!NRST) begin
            sync_level <= 1'b0;
            flt_cnt    <= '0;
        end else if (raw != sync_level) begin
            if (flt_cnt == FLT_W'(GLITCH - 1)) begin
                sync_level <= raw;
                flt_cnt    <= '0;
            end else begin
                flt_cnt <= flt_cnt + FLT_W'(1);
            end
        end else begin
            flt_cnt <= '0;
        end
    end

    assign rise = sync_level & ~sync_d;
    assign fall = ~sync_level & sync_d;

    // Edge history and arming: a pulse already in progress at reset release
    // never saw a genuine low level first, so its rise does not arm.
    always_ff @(posedge clk) begin
        if (!NRST) begin
            sync_d    <= 1'b0;
            idle_seen <= 1'b0;
            armed     <= 1'b0;
        end else begin
            sync_d <= sync_level;
            if (!sync_level && !raw)
                idle_seen <= 1'b1;
            if (rise && idle_seen)
                armed <= 1'b1;
        end
    end

    // Pulse width (from rise) and interval since the last H leading edge
    always_ff @(posedge clk) begin
        if (!NRST) begin
            width         <= '0;
            interval      <= '0;
            rise_interval <= '0;
        end else begin
            if (rise)
                width <= 10'd1;
            else if (sync_level)
                width <= sat_inc10(width);
            // An H pulse rebases the interval to its own leading edge.
            if (is_h)
                interval <= {2'b00, width} + 12'd1;
            else
                interval <= sat_inc12(interval);
            if (rise)
                rise_interval <= interval;
        end
    end

    assign cls_en   = fall & armed;
    assign is_eq    = cls_en && (int'(width) < HSYNC_MIN);
    assign is_h     = cls_en && (int'(width) >= HSYNC_MIN) && (int'(width) <= HSYNC_MAX);
    assign is_broad = cls_en && (int'(width) >= BROAD_MIN);
    assign cls_any  = is_h | is_eq | is_broad;

    // Classify stage: strobes, line counter and broad-pulse run
    always_ff @(posedge clk) begin
        if (!NRST) begin
            hsync_pulse <= 1'b0;
            vsync_pulse <= 1'b0;
            line_count  <= '0;
            broad_run   <= '0;
        end else begin
            hsync_pulse <= is_h;
            vsync_pulse <= is_broad && (broad_run == 2'd2);
            if (is_h) begin
                line_count <= sat_inc10(line_count);
                broad_run  <= '0;
            end else if (is_broad) begin
                if (broad_run != 2'd3)
                    broad_run <= broad_run + 2'd1;
                if (broad_run == 2'd2)
                    line_count <= '0;
            end
        end
    end

`ifdef NTSC_SYNC_FIELD_EN
    logic eq_seen;
    logic field_pend;

    // Field measurement: H-to-first-EQ spacing of a full line means field 0,
    // half a line means field 1; the result is published at vsync.
    always_ff @(posedge clk) begin
        if (!NRST) begin
            eq_seen    <= 1'b0;
            field_pend <= 1'b0;
            field      <= 1'b0;
        end else begin
            if (is_h) begin
                eq_seen <= 1'b0;
            end else if (is_eq) begin
                eq_seen <= 1'b1;
                if (!eq_seen) begin
                    if (within_tol(rise_interval, LINE_NOM))
                        field_pend <= 1'b0;
                    else if (within_tol(rise_interval, LINE_NOM / 2))
                        field_pend <= 1'b1;
                end
            end
            if (is_broad && (broad_run == 2'd2))
                field <= field_pend;
        end
    end
`else
    assign field = 1'b0;
`endif

    // Lock FSM: count good H periods to lock; drop lock only on loss of pulses
    always_ff @(posedge clk) begin
        if (!NRST) begin
            state    <= SEARCH;
            locked   <= 1'b0;
            lock_cnt <= '0;
            tmo      <= '0;
        end else begin
            case (state)
                SEARCH: begin
                    tmo <= '0;
                    if (int'(lock_cnt) == LOCK_LINES) begin
                        state    <= LOCKED;
                        locked   <= 1'b1;
                        lock_cnt <= '0;
                    end else if (is_h) begin
                        if (within_tol(rise_interval, LINE_NOM))
                            lock_cnt <= lock_cnt + LCNT_W'(1);
                        else
                            lock_cnt <= '0;
                    end
                end
                LOCKED: begin
                    if (cls_any) begin
                        tmo <= '0;
                    end else if (int'(tmo) == 2 * LINE_NOM - 1) begin
                        state    <= SEARCH;
                        locked   <= 1'b0;
                        lock_cnt <= '0;
                        tmo      <= '0;
                    end else begin
                        tmo <= tmo + 12'd1;
                    end
                end
                default: begin
                    state  <= SEARCH;
                    locked <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ntsc_sync_detect.sv
// Directed testbench for ntsc_sync_detect: clean lines and lock, glitch
// rejection, both vertical field sequences, loss of sync and reset mid-pulse.
module tb_ntsc_sync_detect;

    logic       clk = 1'b0;
    logic       NRST;
    logic [3:0] vadc;
    logic       sync_level;
    logic       hsync_pulse;
    logic       vsync_pulse;
    logic       field;
    logic       locked;
    logic [9:0] line_count;

`ifdef NTSC_SYNC_FIELD_EN
    localparam int EXP_F1 = 1;
`else
    localparam int EXP_F1 = 0;
`endif

    ntsc_sync_detect dut (
        .clk        (clk),
        .NRST       (NRST),
        .vadc       (vadc),
        .sync_level (sync_level),
        .hsync_pulse(hsync_pulse),
        .vsync_pulse(vsync_pulse),
        .field      (field),
        .locked     (locked),
        .line_count (line_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int   cyc = 0;
    int   h_cnt = 0, v_cnt = 0, sl_cnt = 0;
    int   last_h_cyc = 0, last_v_cyc = 0;
    int   lock_rise_cyc = 0, lock_fall_cyc = 0;
    int   v_lc = -1, v_field = -1;
    logic locked_q = 1'b0;

    // Event monitor, sampled 1 time unit after each rising edge
    always @(posedge clk) begin
        #1;
        cyc = cyc + 1;
        if (hsync_pulse) begin h_cnt = h_cnt + 1; last_h_cyc = cyc; end
        if (vsync_pulse) begin
            v_cnt = v_cnt + 1; last_v_cyc = cyc;
            v_lc = int'(line_count); v_field = int'(field);
        end
        if (sync_level) sl_cnt = sl_cnt + 1;
        if (locked && !locked_q) lock_rise_cyc = cyc;
        if (!locked && locked_q) lock_fall_cyc = cyc;
        locked_q = locked;
    end

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic run(input logic [3:0] v, input int n);
        vadc = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input int w, input int spacing);
        run(4'd0, w);
        run(4'd5, spacing - w);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_sync_level"}, int'(sync_level), 0);
        check({tag, "_hsync"}, int'(hsync_pulse), 0);
        check({tag, "_vsync"}, int'(vsync_pulse), 0);
        check({tag, "_field"}, int'(field), 0);
        check({tag, "_locked"}, int'(locked), 0);
        check({tag, "_line_count"}, int'(line_count), 0);
    endtask

    // Last H, six EQ and six broad pulses; vsync expected at the third broad
    task automatic vert(input string tag, input int first_gap, input int exp_field);
        int h0, v0, c3;
        h0 = h_cnt; v0 = v_cnt; c3 = 0;
        pulse(75, first_gap);
        for (int i = 0; i < 6; i++) pulse(37, 508);
        for (int i = 0; i < 6; i++) begin
            run(4'd0, 435);
            if (i == 2) c3 = cyc;
            run(4'd5, 73);
        end
        check({tag, "_h_count"}, h_cnt - h0, 1);
        check({tag, "_v_count"}, v_cnt - v0, 1);
        check({tag, "_v_latency"}, last_v_cyc - c3, 11);
        check({tag, "_lc_at_vsync"}, v_lc, 0);
        check({tag, "_field_at_vsync"}, v_field, exp_field);
        check({tag, "_field"}, int'(field), exp_field);
        check({tag, "_locked"}, int'(locked), 1);
    endtask

    // Clean lines from SEARCH: lock rises one cycle after the 9th H strobe
    task automatic lock_lines(input string tag, input int n);
        int h0, h9, cset;
        h0 = h_cnt; h9 = 0; cset = 0;
        for (int i = 1; i <= n; i++) begin
            run(4'd0, 75);
            cset = cyc;
            run(4'd5, 941);
            if (i == 8) check({tag, "_unlocked_at_8"}, int'(locked), 0);
            if (i == 9) h9 = last_h_cyc;
        end
        check({tag, "_h_count"}, h_cnt - h0, n);
        check({tag, "_locked"}, int'(locked), 1);
        check({tag, "_lock_rise"}, lock_rise_cyc - h9, 1);
        check({tag, "_h_latency"}, last_h_cyc - cset, 11);
    endtask

    initial begin
        int h0, lc0, s0, v0;
        NRST = 1'b0;
        run(4'd5, 3);
        check_reset_outputs("por");
        NRST = 1'b1;
        run(4'd5, 200);

        lock_lines("clean", 12);
        check("clean_line_count", int'(line_count), 12);

        // Short dip mid-line must not disturb anything
        h0 = h_cnt; lc0 = int'(line_count);
        run(4'd0, 75);
        run(4'd5, 400);
        s0 = sl_cnt;
        run(4'd0, 5);
        run(4'd5, 536);
        check("glitch_sync_level", sl_cnt - s0, 0);
        check("glitch_h_count", h_cnt - h0, 1);
        check("glitch_line_count", int'(line_count), lc0 + 1);
        check("glitch_locked", int'(locked), 1);

        vert("vf1", 508, EXP_F1);
        pulse(75, 1016); pulse(75, 1016);
        check("vf1_lines_after", int'(line_count), 2);

        vert("vf0", 1016, 0);
        pulse(75, 1016); pulse(75, 1016);
        check("vf0_lines_after", int'(line_count), 2);

        // Loss of sync: lock drops 2032 cycles after the last classification
        run(4'd0, 75);
        run(4'd5, 2500);
        check("loss_locked", int'(locked), 0);
        check("loss_timeout", lock_fall_cyc - last_h_cyc, 2032);
        lock_lines("relock", 10);

        vert("vf1b", 508, EXP_F1);
        pulse(75, 1016); pulse(75, 1016);
        check("pre_reset_locked", int'(locked), 1);
        check("pre_reset_field", int'(field), EXP_F1);

        // Reset for three cycles in the middle of a broad pulse
        h0 = h_cnt; v0 = v_cnt;
        run(4'd0, 200);
        NRST = 1'b0;
        run(4'd0, 1);
        check_reset_outputs("midrst");
        run(4'd0, 2);
        NRST = 1'b1;
        run(4'd0, 232);
        run(4'd5, 500);
        check("partial_h_count", h_cnt - h0, 0);
        check("partial_v_count", v_cnt - v0, 0);
        check("partial_line_count", int'(line_count), 0);
        check("partial_sync_level", int'(sync_level), 0);
        pulse(75, 1016);
        check("post_rst_h_count", h_cnt - h0, 1);
        check("post_rst_line_count", int'(line_count), 1);
        check("post_rst_locked", int'(locked), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
